// File: rtl/serial_link_scheduler.sv
// Round-robin arbiter feeding a framed serial transmitter: start bit, 2-bit port,
// 4-bit length (MSB first), payload LSB first, then a stop bit.
module serial_link_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic [3:0]  req,
  input  logic [15:0] req_len,
  input  logic [63:0] req_data,
  output logic [3:0]  gnt,
  output logic        serOut,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_PORT  = 3'd2,
    ST_CNT   = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  last_q;
  logic [1:0]  port_q;
  logic [3:0]  len_q;
  logic [15:0] data_q;
  logic        serout_q;
  logic        busy_q;
  logic [3:0]  gnt_q;
  logic        done_q;

  logic [1:0]  win_d;
  logic        win_vld_d;
  logic [1:0]  idx_d;

  // Round-robin winner search starting just after the last granted requester.
  always_comb begin
    win_d     = last_q;
    win_vld_d = 1'b0;
    idx_d     = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx_d = last_q + k[1:0];
      if (!win_vld_d && req[idx_d]) begin
        win_vld_d = 1'b1;
        win_d     = idx_d;
      end else begin
        win_vld_d = win_vld_d;
      end
    end
  end

  // Frame FSM; outputs are registered with the value they must show in the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 2'd3;
      port_q   <= 2'd0;
      len_q    <= 4'd0;
      data_q   <= 16'd0;
      serout_q <= 1'b1;
      busy_q   <= 1'b0;
      gnt_q    <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      gnt_q  <= 4'b0000;
      done_q <= 1'b0;
      if (clkEn) begin
        case (state_q)
          ST_IDLE: begin
            if (win_vld_d) begin
              port_q   <= win_d;
              len_q    <= req_len[{win_d, 2'b00} +: 4];
              data_q   <= req_data[{win_d, 4'b0000} +: 16];
              last_q   <= win_d;
              gnt_q    <= 4'b0001 << win_d;
              state_q  <= ST_START;
              cnt_q    <= 4'd0;
              serout_q <= 1'b0;
              busy_q   <= 1'b1;
            end else begin
              serout_q <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
          ST_START: begin
            state_q  <= ST_PORT;
            cnt_q    <= 4'd1;
            serout_q <= port_q[1];
          end
          ST_PORT: begin
            if (cnt_q == 4'd0) begin
              state_q  <= ST_CNT;
              cnt_q    <= 4'd3;
              serout_q <= len_q[3];
            end else begin
              cnt_q    <= cnt_q - 4'd1;
              serout_q <= port_q[0];
            end
          end
          // cnt_q holds the length bit currently on the line, counting down to 0.
          ST_CNT: begin
            if (cnt_q != 4'd0) begin
              cnt_q    <= cnt_q - 4'd1;
              serout_q <= len_q[cnt_q[1:0] - 2'd1];
            end else if (len_q != 4'd0) begin
              state_q  <= ST_DATA;
              cnt_q    <= 4'd0;
              serout_q <= data_q[0];
            end else begin
              state_q  <= ST_STOP;
              serout_q <= 1'b1;
            end
          end
          ST_DATA: begin
            if (cnt_q == len_q - 4'd1) begin
              state_q  <= ST_STOP;
              cnt_q    <= 4'd0;
              serout_q <= 1'b1;
            end else begin
              cnt_q    <= cnt_q + 4'd1;
              serout_q <= data_q[cnt_q + 4'd1];
            end
          end
          ST_STOP: begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            serout_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
          default: begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            serout_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gnt    = gnt_q;
  assign serOut = serout_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_link_scheduler.sv
// Directed bench for serial_link_scheduler: frame bit patterns, round-robin order,
// slow bit-rate enable, captured-value isolation and mid-frame reset.
module tb_serial_link_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn = 1'b1;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        serOut;
  logic        busy;
  logic        done;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int en_div   = 1;
  int ph       = 0;

  serial_link_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .clkEn    (clkEn),
    .req      (req),
    .req_len  (req_len),
    .req_data (req_data),
    .gnt      (gnt),
    .serOut   (serOut),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Bit-rate enable: high one clk in every en_div.
  initial begin
    forever begin
      @(negedge clk);
      ph++;
      clkEn = (en_div <= 1) || ((ph % en_div) == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [23:0] build_frame(input logic [1:0] port, input logic [3:0] len,
                                              input logic [15:0] data);
    logic [23:0] f;
    f = 24'd0;
    f[1] = port[1];
    f[2] = port[0];
    for (int k = 0; k < 4; k++) f[3 + k] = len[3 - k];
    for (int i = 0; i < 16; i++) if (i < int'(len)) f[7 + i] = data[i];
    f[7 + int'(len)] = 1'b1;
    return f;
  endfunction

  task automatic run_frame(input string tag, input logic [3:0] exp_gnt, input logic [23:0] bits,
                           input int nbits, input int exp_wait, input logic [3:0] drop,
                           input bit scramble);
    int n;
    n = 0;
    while (gnt == 4'b0000 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_gnt"}, {28'd0, gnt}, {28'd0, exp_gnt});
    if (exp_wait >= 0) check_eq({tag, "_wait"}, n, exp_wait);
    req = req & ~drop;
    if (scramble) begin
      req_len  = ~req_len;
      req_data = ~req_data;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < en_div; c++) begin
        if (b != 0 || c != 0) begin
          @(negedge clk);
          check_eq({tag, "_gnt_low"}, {28'd0, gnt}, 32'd0);
        end
        check_eq({tag, "_bit"}, {31'd0, serOut}, {31'd0, bits[b]});
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check_eq({tag, "_done_low"}, {31'd0, done}, 32'd0);
      end
    end
    @(negedge clk);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_idle_hi"}, {31'd0, serOut}, 32'd1);
    check_eq({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    req      = 4'b0000;
    req_len  = 16'h0000;
    req_data = 64'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_ser", {31'd0, serOut}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_gnt", {28'd0, gnt}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;

    // Requester 2, len 3, data 0x5; inputs scrambled after grant.
    req      = 4'b0100;
    req_len  = 16'h0300;
    req_data = 64'h0000_0005_0000_0000;
    run_frame("f028", 4'b0100, 24'b000000000000011011100010, 11, -1, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("f028_stay_hi", {31'd0, serOut}, 32'd1);
    end

    // Zero-length frame from requester 1.
    req      = 4'b0010;
    req_len  = 16'h0000;
    req_data = 64'hFFFF_FFFF_FFFF_FFFF;
    run_frame("f030", 4'b0010, 24'b000000000000000010000100, 8, -1, 4'b0010, 1'b0);

    // Idle reset, then all requesters held with len 1.
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst2_busy", {31'd0, busy}, 32'd0);
    rst      = 1'b1;
    req      = 4'b1111;
    req_len  = 16'h1111;
    req_data = 64'h0000_0001_0000_0001;
    run_frame("rr0", 4'b0001, build_frame(2'd0, 4'd1, 16'h0001), 9, -1, 4'b0000, 1'b0);
    run_frame("rr1", 4'b0010, build_frame(2'd1, 4'd1, 16'h0000), 9, 0, 4'b0000, 1'b0);
    run_frame("rr2", 4'b0100, build_frame(2'd2, 4'd1, 16'h0001), 9, 0, 4'b0000, 1'b0);
    run_frame("rr3", 4'b1000, build_frame(2'd3, 4'd1, 16'h0000), 9, 0, 4'b0000, 1'b0);
    run_frame("rr4", 4'b0001, build_frame(2'd0, 4'd1, 16'h0001), 9, 0, 4'b1111, 1'b0);

    // Slow bit rate: one enable every 4 clks.
    en_div   = 4;
    req      = 4'b0001;
    req_len  = 16'h0002;
    req_data = 64'h0000_0000_0000_0002;
    run_frame("slow", 4'b0001, build_frame(2'd0, 4'd2, 16'h0002), 10, -1, 4'b0001, 1'b1);
    en_div = 1;
    repeat (4) @(negedge clk);

    // Reset asserted during DATA of a requester 2 frame.
    req      = 4'b0100;
    req_len  = 16'h0400;
    req_data = 64'h0000_000F_0000_0000;
    begin
      int n;
      n = 0;
      while (gnt == 4'b0000 && n < 60) begin
        @(negedge clk);
        n++;
      end
      check_eq("mr_gnt", {28'd0, gnt}, 32'h4);
    end
    req = 4'b0000;
    repeat (7) @(negedge clk);
    check_eq("mr_data_bit", {31'd0, serOut}, 32'd1);
    check_eq("mr_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mr_ser", {31'd0, serOut}, 32'd1);
    check_eq("mr_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mr_no_done", {31'd0, done}, 32'd0);
    end
    req     = 4'b1111;
    req_len = 16'h1111;
    rst     = 1'b1;
    begin
      int n;
      n = 0;
      while (gnt == 4'b0000 && n < 60) begin
        @(negedge clk);
        n++;
      end
      check_eq("mr_first_gnt", {28'd0, gnt}, 32'h1);
    end
    req = 4'b0000;
    repeat (20) @(negedge clk);
    check_eq("end_ser", {31'd0, serOut}, 32'd1);
    check_eq("end_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
